pulse_shaping_filter: RTL and testbench

Transmit pulse-shaping interpolator directly upstream of the halfband interpolator. Accepts one 1s17 symbol per `sym_clk_en` and produces four 1s17 samples per symbol, one per `sam_clk_en`. It implements a 32-tap FIR as a 4-phase polyphase structure (8 taps per phase) on a registered symbol delay line, with a saturating output. Output `y` feeds the halfband's `x_in` on the same `sam_clk_en` strobe.

---
 rtl/tx_filter_pkg.sv | 29 ++
 rtl/polyphase_mac.sv | 32 +++
 rtl/pulse_shaping_filter.sv | 71 +++++++
 tb/tb_pulse_shaping_filter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_filter_pkg.sv
// Shared constants, coefficient table and output saturation for the transmit shaping filter.
package tx_filter_pkg;
  localparam int SAMPLE_W = 18;
  localparam int COEF_W   = 18;
  localparam int PROD_W   = SAMPLE_W + COEF_W;
  localparam int ACC_W    = 39;
  localparam int NPHASE   = 4;
  localparam int NSYM     = 8;

  // 0s18 taps, mirror-symmetric about the centre: H[n] == H[31-n]
  localparam logic [COEF_W-1:0] H_COEF [0:NPHASE*NSYM-1] = '{
    18'd201,   18'd602,   18'd1403,  18'd3000,  18'd5601,  18'd9602,  18'd15203, 18'd22400,
    18'd31201, 18'd41602, 18'd52803, 18'd64800, 18'd76801, 18'd88002, 18'd97603, 18'd104001,
    18'd104001, 18'd97603, 18'd88002, 18'd76801, 18'd64800, 18'd52803, 18'd41602, 18'd31201,
    18'd22400, 18'd15203, 18'd9602,  18'd5601,  18'd3000,  18'd1403,  18'd602,   18'd201
  };

  // 4s35 accumulator to 1s17: floor to the top fraction bits, clamp when the guard bits disagree
  function automatic logic signed [SAMPLE_W-1:0] sat_1s17(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W-PROD_W:0] guard;
    guard = acc[ACC_W-1:PROD_W-1];
    if (guard == '0 || guard == '1)
      return acc[PROD_W-1:COEF_W];
    else if (acc[ACC_W-1])
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/polyphase_mac.sv
// One polyphase branch: 8 symbol x coefficient products summed into 4s35 and saturated to 1s17.
// Purely combinational; no storage and no flow control.
module polyphase_mac
  import tx_filter_pkg::*;
(
  input  logic [NSYM*SAMPLE_W-1:0] s_i,
  input  logic [NSYM*COEF_W-1:0]   coef_i,
  output logic [SAMPLE_W-1:0]      y_o
);

  logic signed [SAMPLE_W-1:0] samp;
  logic signed [COEF_W:0]     coef;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc;

  // Coefficients are unsigned fractions, so a zero sign bit keeps them positive in the multiply
  always_comb begin
    samp = '0;
    coef = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < NSYM; k++) begin
      samp = s_i[k*SAMPLE_W +: SAMPLE_W];
      coef = {1'b0, coef_i[k*COEF_W +: COEF_W]};
      prod = PROD_W'(samp) * PROD_W'(coef);
      acc  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  assign y_o = sat_1s17(acc);

endmodule

// File: rtl/pulse_shaping_filter.sv
// 4x polyphase pulse-shaping interpolator; y reflects the phase sum one sam_clk_en edge after it is formed.
// Strobe-driven with no backpressure: state holds whenever neither enable is asserted.
module pulse_shaping_filter
  import tx_filter_pkg::*;
#(
  parameter int NTAPS = 32
)
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sym_clk_en,
  input  logic                       sam_clk_en,
  input  logic signed [SAMPLE_W-1:0] x_in,
  output logic signed [SAMPLE_W-1:0] y
);

  localparam int IDX_W = $clog2(NTAPS);

  logic [NSYM*SAMPLE_W-1:0]   s_q, s_d;
  logic [1:0]                 ph_q, ph_d;
  logic signed [SAMPLE_W-1:0] y_q, y_d;
  logic [NSYM*COEF_W-1:0]     coef_sel;
  logic [SAMPLE_W-1:0]        mac_y;
  logic [IDX_W-1:0]           idx;

  // Branch k of phase ph uses tap 4k+ph
  always_comb begin
    coef_sel = '0;
    idx      = '0;
    for (int k = 0; k < NSYM; k++) begin
      idx = IDX_W'(k * (NTAPS / NSYM)) + IDX_W'(ph_q);
      coef_sel[k*COEF_W +: COEF_W] = H_COEF[idx];
    end
  end

  polyphase_mac u_mac (
    .s_i    (s_q),
    .coef_i (coef_sel),
    .y_o    (mac_y)
  );

  // On a coincident strobe y takes the old symbol set's last phase while the line shifts
  always_comb begin
    s_d  = s_q;
    ph_d = ph_q;
    y_d  = y_q;
    if (sym_clk_en) begin
      s_d  = {s_q[(NSYM-1)*SAMPLE_W-1:0], x_in};
      ph_d = 2'd0;
    end else if (sam_clk_en) begin
      ph_d = ph_q + 2'd1;
    end
    if (sam_clk_en)
      y_d = mac_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q  <= '0;
      ph_q <= '0;
      y_q  <= '0;
    end else begin
      s_q  <= s_d;
      ph_q <= ph_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_pulse_shaping_filter.sv
// Bench for pulse_shaping_filter: zero-stuffed convolution model checked every cycle, plus literal impulse/clamp points.
module tb_pulse_shaping_filter;

  logic               clk;
  logic               reset;
  logic               sym_clk_en;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_shaping_filter #(.NTAPS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_clk_en (sym_clk_en),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .y          (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent copy of the first half of the impulse response; the second half mirrors it
  int H_HALF [16] = '{201, 602, 1403, 3000, 5601, 9602, 15203, 22400,
                      31201, 41602, 52803, 64800, 76801, 88002, 97603, 104001};

  function automatic longint h(input int n);
    return (n < 16) ? longint'(H_HALF[n]) : longint'(H_HALF[31-n]);
  endfunction

  longint sym_hist [8];
  int     ph_m;
  longint y_m;
  bit     model_ready = 1'b0;
  longint ylog [$];

  // Output = full 32-tap FIR over the zero-stuffed stream, symbol k sitting at offset 4k+ph
  function automatic longint model_out();
    longint up [32];
    longint acc;
    acc = 0;
    for (int n = 0; n < 32; n++) up[n] = 0;
    for (int k = 0; k < 8; k++) up[4*k + ph_m] = sym_hist[k];
    for (int n = 0; n < 32; n++) acc += h(n) * up[n];
    acc = acc >>> 18;
    if (acc > 131071) acc = 131071;
    else if (acc < -131072) acc = -131072;
    return acc;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) sym_hist[k] = 0;
      ph_m = 0;
      y_m = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      if (sam_clk_en) begin
        y_m = model_out();
        ylog.push_back(y_m);
      end
      if (sym_clk_en) begin
        for (int k = 7; k > 0; k--) sym_hist[k] = sym_hist[k-1];
        sym_hist[0] = longint'(x_in);
        ph_m = 0;
      end else if (sam_clk_en) begin
        ph_m = (ph_m + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      n_checks++;
      if ($isunknown(y) || longint'(y) != y_m) begin
        n_fail++;
        $display("FAIL y_cycle t=%0t dut=%0d model=%0d", $time, y, y_m);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input longint exp);
    if (idx >= ylog.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s log index %0d missing (size %0d) required=%0d", name, idx, ylog.size(), exp);
    end else begin
      chk(name, ylog[idx], exp);
    end
  endtask

  task automatic tick(input logic r, input logic sy, input logic sa, input logic signed [17:0] x);
    @(negedge clk);
    reset = r;
    sym_clk_en = sy;
    sam_clk_en = sa;
    x_in = x;
  endtask

  // One symbol period: 16 clocks, sample strobe every 4, symbol strobe on the first
  task automatic sym_period(input logic signed [17:0] v);
    for (int j = 0; j < 16; j++) tick(1'b0, j == 0, (j % 4) == 0, v);
  endtask

  logic signed [17:0] tbl [8] = '{18'sd30000, -18'sd20000, 18'sd12345, -18'sd70000,
                                  18'sd0, 18'sd99999, -18'sd5, 18'sd40000};

  initial begin
    reset = 1'b1; sym_clk_en = 1'b0; sam_clk_en = 1'b0; x_in = '0;

    // Reset held with both strobes active
    repeat (3) tick(1'b1, 1'b1, 1'b1, 18'sd65536);
    tick(1'b0, 1'b0, 1'b1, 18'sd0);
    @(posedge clk); #1;
    chk("reset_first_sample", longint'(y), 0);
    tick(1'b0, 1'b0, 1'b0, 18'sd0);

    // Positive impulse
    ylog.delete();
    sym_period(18'sd65536);
    repeat (9) sym_period(18'sd0);
    chk_log("imp_h0", 1, 50);
    chk_log("imp_h1", 2, 150);
    chk_log("imp_h15", 16, 26000);
    chk_log("imp_h31", 32, 50);
    chk_log("imp_tail", 33, 0);
    for (int n = 0; n < 32; n++) chk_log("imp_seq", n + 1, h(n) >>> 2);

    // Negative impulse: floor rounds away from zero, response stays symmetric
    ylog.delete();
    sym_period(-18'sd65536);
    repeat (9) sym_period(18'sd0);
    chk_log("nimp_h0", 1, -51);
    chk_log("nimp_h1", 2, -151);
    chk_log("nimp_h15", 16, -26001);
    for (int n = 0; n < 16; n++)
      if (ylog.size() > 32) chk("nimp_sym", ylog[1 + n], ylog[32 - n]);

    // Positive and negative full-scale clamp
    ylog.delete();
    repeat (10) sym_period(18'sd131071);
    for (int i = 36; i < 40; i++) chk_log("sat_pos", i, 131071);
    ylog.delete();
    repeat (10) sym_period(-18'sd131072);
    for (int i = 36; i < 40; i++) chk_log("sat_neg", i, -131072);

    // Mixed stream, with a 20-clock idle gap inside one symbol
    for (int i = 0; i < 8; i++) sym_period(tbl[i]);
    for (int j = 0; j < 16; j++) begin
      tick(1'b0, j == 0, (j % 4) == 0, 18'sd30000);
      if (j == 9) repeat (20) tick(1'b0, 1'b0, 1'b0, 18'sd0);
    end
    sym_period(-18'sd45000);

    // Isolated symbol strobe, then more sample strobes than phases
    tick(1'b0, 1'b1, 1'b0, 18'sd50000);
    repeat (6) begin
      tick(1'b0, 1'b0, 1'b1, 18'sd0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 18'sd0);
    end
    repeat (8) sym_period(18'sd0);

    // Reset during phase 2 of a symbol
    tick(1'b0, 1'b1, 1'b1, 18'sd65536);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 18'sd0);
    tick(1'b0, 1'b0, 1'b1, 18'sd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 18'sd0);
    tick(1'b0, 1'b0, 1'b1, 18'sd0);
    tick(1'b0, 1'b0, 1'b0, 18'sd0);
    ylog.delete();
    tick(1'b1, 1'b0, 1'b1, 18'sd65536);
    repeat (2) begin
      tick(1'b0, 1'b0, 1'b1, 18'sd0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 18'sd0);
    end
    chk_log("rst_mid_zero0", 0, 0);
    chk_log("rst_mid_zero1", 1, 0);
    ylog.delete();
    sym_period(18'sd65536);
    repeat (8) sym_period(18'sd0);
    chk_log("rst_imp_h0", 1, 50);
    chk_log("rst_imp_h3", 4, 750);
    chk_log("rst_imp_h4", 5, 1400);
    chk_log("rst_imp_h31", 32, 50);

    tick(1'b0, 1'b0, 1'b0, 18'sd0);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
